// File: rtl/dpram_fifo_ctrl_if.sv
// Producer/consumer stream bundle for dpram_fifo_ctrl.
// Handshake: a word moves on a rising edge where valid and ready are both high.
// valid may not wait for ready, and data holds steady while valid waits.
interface dpram_fifo_ctrl_if #(
    parameter int DW = 8
);
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_ready;

    modport master (
        output wr_valid, wr_data, rd_ready,
        input  wr_ready, rd_valid, rd_data
    );

    modport slave (
        input  wr_valid, wr_data, rd_ready,
        output wr_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/dpram_fifo_ctrl.sv
// First-word-fall-through FIFO controller wrapped around an external dual-port RAM.
// Port A takes stream writes; port B prefetches into a 2-entry in-order skid buffer.
module dpram_fifo_ctrl #(
    parameter int AW    = 8,
    parameter int DW    = 8,
    parameter int DEPTH = 256
) (
    input  logic          clk,
    input  logic          reset,
    dpram_fifo_ctrl_if.slave s_if,
    output logic [AW:0]   ram_level,
    output logic          write_enable_A,
    output logic [AW-1:0] address_A,
    output logic [DW-1:0] data_in_A,
    output logic          write_enable_B,
    output logic [AW-1:0] address_B,
    output logic [DW-1:0] data_in_B,
    input  logic [DW-1:0] data_out_B
);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   ram_level_q, ram_level_d;
    logic          pending_q, pending_d;
    logic [1:0]    skid_cnt_q, skid_cnt_d;
    logic [DW-1:0] skid_q [2];
    logic [DW-1:0] skid_d [2];

    logic          wr_ready_w;
    logic          wr_fire;
    logic          pop;
    logic          issue;
    logic [2:0]    occ;
    logic [1:0]    cnt;

    always_comb begin
        wr_ready_w  = (ram_level_q != FULL_LVL);
        wr_fire     = s_if.wr_valid & wr_ready_w;
        pop         = (skid_cnt_q != 2'd0) & s_if.rd_ready;
        // Words already held or in flight after this edge's pop must leave room.
        occ         = {1'b0, skid_cnt_q} + {2'b00, pending_q} - {2'b00, pop};
        issue       = (ram_level_q != '0) && (occ < 3'd2);

        wr_ptr_d    = wr_fire ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = issue ? rd_ptr_q + 1'b1 : rd_ptr_q;
        pending_d   = issue;
        ram_level_d = ram_level_q + (AW+1)'(wr_fire) - (AW+1)'(issue);

        skid_d[0]   = skid_q[0];
        skid_d[1]   = skid_q[1];
        cnt         = skid_cnt_q;
        if (pop) begin
            skid_d[0] = skid_q[1];
            cnt       = cnt - 2'd1;
        end
        // Capture lands at the tail, which is below 2 whenever a read was pending.
        if (pending_q) begin
            skid_d[cnt[0]] = data_out_B;
            cnt            = cnt + 2'd1;
        end
        skid_cnt_d  = cnt;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_level_q <= '0;
            pending_q   <= 1'b0;
            skid_cnt_q  <= 2'd0;
            skid_q[0]   <= '0;
            skid_q[1]   <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_level_q <= ram_level_d;
            pending_q   <= pending_d;
            skid_cnt_q  <= skid_cnt_d;
            skid_q[0]   <= skid_d[0];
            skid_q[1]   <= skid_d[1];
        end
    end

    assign s_if.wr_ready = wr_ready_w;
    assign s_if.rd_valid = (skid_cnt_q != 2'd0);
    assign s_if.rd_data  = skid_q[0];
    assign ram_level     = ram_level_q;
    assign write_enable_A = wr_fire;
    assign address_A     = wr_ptr_q;
    assign data_in_A     = s_if.wr_data;
    assign write_enable_B = 1'b0;
    assign address_B     = rd_ptr_q;
    assign data_in_B     = '0;
endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl: behavioural dual-port RAM, stream drivers and an
// in-order scoreboard checked whenever the consumer side pops a word.
module tb_dpram_fifo_ctrl;
    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 256;

    logic          clk;
    logic          reset;
    logic [AW:0]   ram_level;
    logic          write_enable_A;
    logic [AW-1:0] address_A;
    logic [DW-1:0] data_in_A;
    logic          write_enable_B;
    logic [AW-1:0] address_B;
    logic [DW-1:0] data_in_B;
    logic [DW-1:0] data_out_B;

    dpram_fifo_ctrl_if #(.DW(DW)) bif ();

    dpram_fifo_ctrl #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .s_if           (bif.slave),
        .ram_level      (ram_level),
        .write_enable_A (write_enable_A),
        .address_A      (address_A),
        .data_in_A      (data_in_A),
        .write_enable_B (write_enable_B),
        .address_B      (address_B),
        .data_in_B      (data_in_B),
        .data_out_B     (data_out_B)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- RAM model (registered port B read) ----------------
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (write_enable_A) mem[address_A] <= data_in_A;
        data_out_B <= mem[address_B];
    end

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int pop_cnt = 0;
    int gap_cnt = 0;
    bit stream_on = 0;
    bit seen_first = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
        end else begin
            if (bif.wr_valid && bif.wr_ready) exp_q.push_back(bif.wr_data);
            if (bif.rd_valid && bif.rd_ready) begin
                pop_cnt++;
                if (exp_q.size() == 0) check("pop_nonempty", 32'd0, 32'd1);
                else check("rd_data", 32'(bif.rd_data), 32'(exp_q.pop_front()));
            end
            if (stream_on && seen_first && !bif.rd_valid) gap_cnt++;
            if (stream_on && bif.rd_valid) seen_first = 1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d);
        int n;
        n = 0;
        bif.wr_valid = 1'b1;
        bif.wr_data  = d;
        forever begin
            @(negedge clk);
            if (bif.wr_ready) break;
            n++;
            if (n > 2000) begin
                check("send_timeout", 32'd1, 32'd0);
                break;
            end
        end
        tick();
        bif.wr_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        bif.rd_ready = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            tick();
            if (exp_q.size() == 0) break;
        end
        bif.rd_ready = 1'b0;
        check({tag, "_q_empty"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_rd_valid"}, 32'(bif.rd_valid), 32'd0);
        check({tag, "_level"}, 32'(ram_level), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset        = 1'b0;
        bif.wr_valid = 1'b0;
        bif.wr_data  = '0;
        bif.rd_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;

        check("rst_wr_ready", 32'(bif.wr_ready), 32'd1);
        check("rst_rd_valid", 32'(bif.rd_valid), 32'd0);
        check("rst_level", 32'(ram_level), 32'd0);
        check("rst_we_a", 32'(write_enable_A), 32'd0);
        check("rst_addr_a", 32'(address_A), 32'd0);
        check("rst_addr_b", 32'(address_B), 32'd0);
        check("rst_we_b", 32'(write_enable_B), 32'd0);
        check("rst_din_b", 32'(data_in_B), 32'd0);

        // Single word: visible two edges after acceptance.
        bif.wr_valid = 1'b1;
        bif.wr_data  = 8'h0F;
        @(negedge clk);
        check("one_we_a", 32'(write_enable_A), 32'd1);
        check("one_addr_a", 32'(address_A), 32'd0);
        check("one_din_a", 32'(data_in_A), 32'h0F);
        tick();
        bif.wr_valid = 1'b0;
        check("one_e0_valid", 32'(bif.rd_valid), 32'd0);
        check("one_e0_level", 32'(ram_level), 32'd1);
        tick();
        check("one_e1_valid", 32'(bif.rd_valid), 32'd0);
        check("one_e1_level", 32'(ram_level), 32'd0);
        tick();
        check("one_e2_valid", 32'(bif.rd_valid), 32'd1);
        check("one_e2_data", 32'(bif.rd_data), 32'h0F);
        bif.rd_ready = 1'b1;
        tick();
        bif.rd_ready = 1'b0;
        check("one_pop_valid", 32'(bif.rd_valid), 32'd0);
        check("one_pop_level", 32'(ram_level), 32'd0);

        // Burst with consumer stalled.
        for (int i = 1; i <= 5; i++) begin
            bif.wr_valid = 1'b1;
            bif.wr_data  = DW'(i);
            @(negedge clk);
            check("burst_addr_a", 32'(address_A), 32'(i));
            tick();
        end
        bif.wr_valid = 1'b0;
        repeat (4) tick();
        check("burst_level", 32'(ram_level), 32'd3);
        check("burst_head", 32'(bif.rd_data), 32'h01);
        bif.rd_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("burst_stream_valid", 32'(bif.rd_valid), 32'd1);
            tick();
        end
        bif.rd_ready = 1'b0;
        check("burst_q_empty", 32'(exp_q.size()), 32'd0);

        // Full: DEPTH + 2 words fit, the next one is refused.
        for (int i = 0; i < DEPTH + 2; i++) send(DW'(i * 3 + 7));
        repeat (3) tick();
        check("full_wr_ready", 32'(bif.wr_ready), 32'd0);
        check("full_level", 32'(ram_level), 32'(DEPTH));
        bif.wr_valid = 1'b1;
        bif.wr_data  = 8'hAA;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_we_a", 32'(write_enable_A), 32'd0);
            tick();
        end
        bif.wr_valid = 1'b0;
        pop_cnt = 0;
        drain("full");
        check("full_pop_cnt", 32'(pop_cnt), 32'(DEPTH + 2));

        // Streaming across two pointer wraps.
        pop_cnt    = 0;
        gap_cnt    = 0;
        seen_first = 0;
        stream_on  = 1;
        bif.rd_ready = 1'b1;
        for (int i = 0; i < 600; i++) send(DW'(i + $urandom_range(0, 0)));
        stream_on = 0;
        drain("stream");
        check("stream_pop_cnt", 32'(pop_cnt), 32'd600);
        check("stream_gaps", 32'(gap_cnt), 32'd0);

        // Reset while words are buffered and a port B read is in flight.
        for (int i = 0; i < 10; i++) send(DW'($urandom_range(0, 255)));
        repeat (3) tick();
        bif.rd_ready = 1'b1;
        tick();
        bif.rd_ready = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("mid_rst_valid", 32'(bif.rd_valid), 32'd0);
        check("mid_rst_level", 32'(ram_level), 32'd0);
        check("mid_rst_wr_ready", 32'(bif.wr_ready), 32'd1);
        send(8'h05);
        repeat (2) tick();
        check("mid_rst_head", 32'(bif.rd_data), 32'h05);
        drain("mid_rst");

        // Simultaneous write and issue with one word in RAM.
        for (int i = 0; i < 3; i++) send(DW'(8'h40 + i));
        repeat (3) tick();
        check("sim_level_before", 32'(ram_level), 32'd1);
        bif.wr_valid = 1'b1;
        bif.wr_data  = 8'h77;
        bif.rd_ready = 1'b1;
        tick();
        bif.wr_valid = 1'b0;
        bif.rd_ready = 1'b0;
        check("sim_level_after", 32'(ram_level), 32'd1);
        drain("sim");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
